// File: rtl/ghost_pkg.sv
// Shared types and constants for the GhostSD OTP keystream path.
package ghost_pkg;

  localparam int unsigned CNT_W_DEF = 16;

  // FSM encoding kept as plain constants for compatibility with older tools
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Index of one of the two keystream buffers
  typedef logic buf_idx_t;

endpackage

// File: rtl/otp_pingpong_ctrl_if.sv
// Handshake bundle between the ping-pong scheduler, sd and otp_gen.
interface otp_pingpong_ctrl_if
  import ghost_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
);

  logic             istart;
  logic [CNT_W-1:0] iblock_count;
  logic             ogen_otp;
  logic             onew_otp;
  logic             iotp_done;
  buf_idx_t         owsel;
  buf_idx_t         orsel;
  logic             ootp_ready;
  logic             irelease;
  logic [CNT_W-1:0] oblock_idx;
  logic             obusy;
  logic             odone;
  logic             oerr;

  // Driver side: session control, otp_gen completion and sd release
  modport master (
    output istart, iblock_count, iotp_done, irelease,
    input  ogen_otp, onew_otp, owsel, orsel, ootp_ready,
           oblock_idx, obusy, odone, oerr
  );

  // Scheduler side
  modport slave (
    input  istart, iblock_count, iotp_done, irelease,
    output ogen_otp, onew_otp, owsel, orsel, ootp_ready,
           oblock_idx, obusy, odone, oerr
  );

endinterface

// File: rtl/otp_pingpong_ctrl.sv
// Ping-pong scheduler: overlaps otp_gen fills of one buffer with sd reads of the other.
module otp_pingpong_ctrl
  import ghost_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                iclk,
  input  logic                irst,
  otp_pingpong_ctrl_if.slave  bus
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] gen_cnt_q, gen_cnt_d;
  logic [CNT_W-1:0] rel_cnt_q, rel_cnt_d;
  logic [1:0]       valid_q, valid_d;
  buf_idx_t         wsel_q, wsel_d;
  buf_idx_t         rsel_q, rsel_d;
  logic             gen_busy_q, gen_busy_d;
  logic             gen_otp_q, gen_otp_d;
  logic             new_otp_q, new_otp_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             gen_elig;
  logic             err_set;

  // Next-state: generator issue/complete, consumer release and session FSM
  always_comb begin
    state_d    = state_q;
    total_d    = total_q;
    gen_cnt_d  = gen_cnt_q;
    rel_cnt_d  = rel_cnt_q;
    valid_d    = valid_q;
    wsel_d     = wsel_q;
    rsel_d     = rsel_q;
    gen_busy_d = gen_busy_q;
    gen_otp_d  = 1'b0;
    new_otp_d  = 1'b0;
    err_d      = err_q;
    err_set    = 1'b0;

    gen_elig = (state_q == ST_RUN) && !gen_busy_q && !valid_q[wsel_q] &&
               (gen_cnt_q < total_q);

    if (gen_elig) begin
      gen_otp_d  = 1'b1;
      new_otp_d  = (gen_cnt_q != '0);
      gen_busy_d = 1'b1;
    end

    // A completion only counts if a generation is outstanding
    if (bus.iotp_done) begin
      if (gen_busy_q) begin
        valid_d[wsel_q] = 1'b1;
        wsel_d          = ~wsel_q;
        gen_cnt_d       = gen_cnt_q + CNT_W'(1);
        gen_busy_d      = 1'b0;
      end else begin
        err_set = 1'b1;
      end
    end

    // A release only counts if the offered buffer holds keystream
    if (bus.irelease) begin
      if (ready_q) begin
        valid_d[rsel_q] = 1'b0;
        rsel_d          = ~rsel_q;
        rel_cnt_d       = rel_cnt_q + CNT_W'(1);
      end else begin
        err_set = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.istart) begin
          err_d = 1'b0;
          if (bus.iblock_count == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d    = ST_RUN;
            total_d    = bus.iblock_count;
            gen_cnt_d  = '0;
            rel_cnt_d  = '0;
            valid_d    = 2'b00;
            wsel_d     = 1'b0;
            rsel_d     = 1'b0;
            gen_busy_d = 1'b0;
          end
        end
      end
      ST_RUN: begin
        if (rel_cnt_q == total_q) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (err_set) err_d = 1'b1;

    done_d  = (state_d == ST_DONE);
    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_RUN) && valid_d[rsel_d];
  end

  // State and output registers, synchronous active-low reset
  always_ff @(posedge iclk) begin
    if (!irst) begin
      state_q    <= ST_IDLE;
      total_q    <= '0;
      gen_cnt_q  <= '0;
      rel_cnt_q  <= '0;
      valid_q    <= 2'b00;
      wsel_q     <= 1'b0;
      rsel_q     <= 1'b0;
      gen_busy_q <= 1'b0;
      gen_otp_q  <= 1'b0;
      new_otp_q  <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      total_q    <= total_d;
      gen_cnt_q  <= gen_cnt_d;
      rel_cnt_q  <= rel_cnt_d;
      valid_q    <= valid_d;
      wsel_q     <= wsel_d;
      rsel_q     <= rsel_d;
      gen_busy_q <= gen_busy_d;
      gen_otp_q  <= gen_otp_d;
      new_otp_q  <= new_otp_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.ogen_otp   = gen_otp_q;
  assign bus.onew_otp   = new_otp_q;
  assign bus.owsel      = wsel_q;
  assign bus.orsel      = rsel_q;
  assign bus.ootp_ready = ready_q;
  assign bus.oblock_idx = rel_cnt_q;
  assign bus.obusy      = busy_q;
  assign bus.odone      = done_q;
  assign bus.oerr       = err_q;

endmodule

// File: tb/tb_otp_pingpong_ctrl.sv
// Bench for otp_pingpong_ctrl: count-based buffer model plus directed scenarios.
module tb_otp_pingpong_ctrl;

  logic iclk;
  logic irst;

  otp_pingpong_ctrl_if bus ();

  otp_pingpong_ctrl dut (
    .iclk (iclk),
    .irst (irst),
    .bus  (bus)
  );

  initial begin
    iclk = 1'b0;
    forever #5 iclk = ~iclk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: session phase, completed generations, releases, one outstanding generation
  int   m_st;      // 0 idle, 1 run, 2 done
  int   m_total, m_comp, m_rel, m_rel0;
  bit   m_fly, m_err, m_elig, m_rdy, m_ev_err;
  logic e_gen, e_new, e_done, e_busy, e_ready, e_wsel, e_rsel, e_err;
  logic [15:0] e_idx;

  always @(posedge iclk) begin
    if (!irst) begin
      m_st = 0; m_total = 0; m_comp = 0; m_rel = 0; m_fly = 0; m_err = 0;
      e_gen = 0; e_new = 0; e_done = 0; e_busy = 0; e_ready = 0;
      e_wsel = 0; e_rsel = 0; e_err = 0; e_idx = '0;
    end else begin
      m_elig   = (m_st == 1) && !m_fly && (m_comp - m_rel) < 2 && m_comp < m_total;
      m_rdy    = (m_st == 1) && (m_comp - m_rel) > 0;
      m_ev_err = 0;
      m_rel0   = m_rel;
      e_gen    = m_elig;
      e_new    = m_elig && (m_comp != 0);
      if (bus.iotp_done) begin
        if (m_fly) begin m_comp++; m_fly = 0; end
        else m_ev_err = 1;
      end
      if (m_elig) m_fly = 1;
      if (bus.irelease) begin
        if (m_rdy) m_rel++;
        else m_ev_err = 1;
      end
      case (m_st)
        0: if (bus.istart) begin
             m_err = 0;
             if (bus.iblock_count == 0) m_st = 2;
             else begin
               m_st = 1; m_total = int'(bus.iblock_count);
               m_comp = 0; m_rel = 0; m_fly = 0;
             end
           end
        1: if (m_rel0 == m_total) m_st = 2;
        default: m_st = 0;
      endcase
      if (m_ev_err) m_err = 1;
      e_done  = (m_st == 2);
      e_busy  = (m_st != 0);
      e_ready = (m_st == 1) && (m_comp - m_rel) > 0;
      e_wsel  = m_comp[0];
      e_rsel  = m_rel[0];
      e_idx   = 16'(m_rel);
      e_err   = m_err;
    end
  end

  // Every-cycle comparison of DUT outputs against the model
  bit chk_en = 0;
  always @(negedge iclk) begin
    if (chk_en) begin
      chk("ogen_otp",   32'(bus.ogen_otp),   32'(e_gen));
      chk("onew_otp",   32'(bus.onew_otp),   32'(e_new));
      chk("owsel",      32'(bus.owsel),      32'(e_wsel));
      chk("orsel",      32'(bus.orsel),      32'(e_rsel));
      chk("ootp_ready", 32'(bus.ootp_ready), 32'(e_ready));
      chk("oblock_idx", 32'(bus.oblock_idx), 32'(e_idx));
      chk("obusy",      32'(bus.obusy),      32'(e_busy));
      chk("odone",      32'(bus.odone),      32'(e_done));
      chk("oerr",       32'(bus.oerr),       32'(e_err));
    end
  end

  // Stimulus drivers and reactive otp_gen / sd models
  logic        drv_start = 0, drv_done = 0, drv_rel = 0, drv_rst = 1;
  logic [15:0] drv_cnt = '0;
  bit          auto_gen = 0, auto_rel = 0;
  int          gen_lat = 50, rel_lat = 20;
  int          gen_timer = -1, rel_timer = -1;
  int          tick_n = 0, gens = 0, dones = 0;
  int          last_gen_tick = 0, last_rel_tick = 0;
  logic        new_log[$], wsel_log[$], rsel_log[$];

  task automatic tick();
    logic d, r;
    @(negedge iclk);
    tick_n++;
    d = drv_done;
    r = drv_rel;
    if (bus.ogen_otp) begin
      gens++;
      new_log.push_back(bus.onew_otp);
      wsel_log.push_back(bus.owsel);
      last_gen_tick = tick_n;
    end
    if (bus.odone) dones++;
    if (auto_gen) begin
      if (gen_timer == 0) begin d = 1'b1; gen_timer = -1; end
      else if (gen_timer > 0) gen_timer--;
      if (bus.ogen_otp) gen_timer = gen_lat;
    end
    if (auto_rel) begin
      if (rel_timer == 0) begin r = 1'b1; rel_timer = -1; end
      else if (rel_timer > 0) rel_timer--;
      else if (bus.ootp_ready) rel_timer = rel_lat;
    end
    if (r && bus.ootp_ready) begin
      rsel_log.push_back(bus.orsel);
      last_rel_tick = tick_n;
    end
    if (!drv_rst) begin gen_timer = -1; rel_timer = -1; end
    bus.istart       = drv_start;
    bus.iblock_count = drv_cnt;
    bus.iotp_done    = d;
    bus.irelease     = r;
    irst             = drv_rst;
    drv_start = 0; drv_done = 0; drv_rel = 0; drv_rst = 1;
  endtask

  task automatic run_until_done(input int budget, input string nm);
    int d0, n;
    d0 = dones; n = 0;
    while (dones == d0 && n < budget) begin tick(); n++; end
    if (dones == d0) begin
      errors++;
      $display("FAIL %s timeout waiting for odone after %0d cycles", nm, budget);
    end
  endtask

  task automatic wait_gen(input string nm);
    int g0, n;
    g0 = gens; n = 0;
    while (gens == g0 && n < 20) begin tick(); n++; end
    if (gens == g0) begin
      errors++;
      $display("FAIL %s timeout waiting for ogen_otp", nm);
    end
  endtask

  task automatic clear_logs();
    gens = 0; dones = 0;
    new_log.delete(); wsel_log.delete(); rsel_log.delete();
  endtask

  initial begin
    int t0, g0, d0;
    bus.istart = 0; bus.iblock_count = '0; bus.iotp_done = 0; bus.irelease = 0;
    irst = 0;

    // Reset
    drv_rst = 0; tick();
    chk_en = 1;
    drv_rst = 0; tick();
    tick();
    chk("rst_obusy", 32'(bus.obusy), 32'd0);
    chk("rst_ready", 32'(bus.ootp_ready), 32'd0);
    chk("rst_idx",   32'(bus.oblock_idx), 32'd0);
    chk("rst_err",   32'(bus.oerr), 32'd0);

    // Zero-length session
    clear_logs();
    drv_start = 1; drv_cnt = 16'd0; tick();
    tick();
    chk("zero_odone", 32'(bus.odone), 32'd1);
    chk("zero_busy",  32'(bus.obusy), 32'd1);
    tick();
    chk("zero_odone_end", 32'(bus.odone), 32'd0);
    chk("zero_busy_end",  32'(bus.obusy), 32'd0);
    repeat (5) tick();
    chk("zero_no_gen", 32'(gens), 32'd0);
    chk("zero_one_done", 32'(dones), 32'd1);

    // Three-block session
    clear_logs();
    auto_gen = 1; auto_rel = 1; gen_lat = 50; rel_lat = 20;
    drv_start = 1; drv_cnt = 16'd3; tick();
    t0 = tick_n;
    run_until_done(2000, "three_block");
    tick(); tick();
    chk("three_gens", 32'(gens), 32'd3);
    chk("three_first_gen_lat", 32'(wsel_log.size() > 0 ? 0 : 1), 32'd0);
    if (new_log.size() == 3) begin
      chk("three_new0", 32'(new_log[0]), 32'd0);
      chk("three_new1", 32'(new_log[1]), 32'd1);
      chk("three_new2", 32'(new_log[2]), 32'd1);
      chk("three_wsel0", 32'(wsel_log[0]), 32'd0);
      chk("three_wsel1", 32'(wsel_log[1]), 32'd1);
      chk("three_wsel2", 32'(wsel_log[2]), 32'd0);
    end else chk("three_log_size", 32'(new_log.size()), 32'd3);
    if (rsel_log.size() == 3) begin
      chk("three_rsel0", 32'(rsel_log[0]), 32'd0);
      chk("three_rsel1", 32'(rsel_log[1]), 32'd1);
      chk("three_rsel2", 32'(rsel_log[2]), 32'd0);
    end else chk("three_rsel_size", 32'(rsel_log.size()), 32'd3);
    chk("three_idx",   32'(bus.oblock_idx), 32'd3);
    chk("three_dones", 32'(dones), 32'd1);
    chk("three_busy",  32'(bus.obusy), 32'd0);

    // Slow consumer: generator stalls with both buffers full
    clear_logs();
    rel_lat = 500;
    drv_start = 1; drv_cnt = 16'd4; tick();
    t0 = tick_n;
    repeat (2) tick();
    chk("first_gen_lat", 32'(last_gen_tick - t0), 32'd2);
    repeat (298) tick();
    chk("slow_gens_stall", 32'(gens), 32'd2);
    chk("slow_ready", 32'(bus.ootp_ready), 32'd1);
    g0 = 0;
    while (gens == 2 && g0 < 600) begin tick(); g0++; end
    chk("slow_gen_after_rel", 32'(last_gen_tick - last_rel_tick), 32'd2);
    run_until_done(4000, "slow_consumer");
    tick(); tick();
    chk("slow_idx", 32'(bus.oblock_idx), 32'd4);

    // Reset mid-session with both buffers valid
    clear_logs();
    auto_rel = 0; rel_timer = -1;
    drv_start = 1; drv_cnt = 16'd4; tick();
    repeat (200) tick();
    chk("midrst_ready_pre", 32'(bus.ootp_ready), 32'd1);
    chk("midrst_gens_pre", 32'(gens), 32'd2);
    d0 = dones;
    drv_rst = 0; tick();
    tick();
    chk("midrst_busy",  32'(bus.obusy), 32'd0);
    chk("midrst_ready", 32'(bus.ootp_ready), 32'd0);
    chk("midrst_gen",   32'(bus.ogen_otp), 32'd0);
    chk("midrst_wsel",  32'(bus.owsel), 32'd0);
    repeat (20) tick();
    chk("midrst_no_done", 32'(dones), 32'(d0));

    // Same-cycle completion and release, then protocol errors
    clear_logs();
    auto_gen = 0; gen_timer = -1;
    drv_start = 1; drv_cnt = 16'd3; tick();
    wait_gen("sc_gen1");
    repeat (3) tick();
    drv_done = 1; tick();
    wait_gen("sc_gen2");
    drv_done = 1; drv_rel = 1; tick();
    tick();
    chk("sc_idx",   32'(bus.oblock_idx), 32'd1);
    chk("sc_orsel", 32'(bus.orsel), 32'd1);
    chk("sc_owsel", 32'(bus.owsel), 32'd0);
    chk("sc_ready", 32'(bus.ootp_ready), 32'd1);
    wait_gen("sc_gen3");
    drv_rel = 1; tick();
    tick();
    chk("sc_ready_empty", 32'(bus.ootp_ready), 32'd0);
    drv_rel = 1; tick();
    tick();
    chk("err_rel_oerr", 32'(bus.oerr), 32'd1);
    chk("err_rel_busy", 32'(bus.obusy), 32'd1);
    chk("err_rel_idx",  32'(bus.oblock_idx), 32'd2);
    drv_done = 1; tick();
    tick();
    drv_rel = 1; tick();
    run_until_done(20, "sc_finish");
    tick();
    chk("sc_err_sticky", 32'(bus.oerr), 32'd1);

    drv_start = 1; drv_cnt = 16'd1; tick();
    tick();
    chk("start_clears_err", 32'(bus.oerr), 32'd0);
    auto_gen = 1; auto_rel = 1; gen_lat = 5; rel_lat = 3;
    run_until_done(200, "one_block");
    auto_gen = 0; auto_rel = 0;
    repeat (3) tick();
    drv_done = 1; tick();
    tick();
    chk("stray_done_err", 32'(bus.oerr), 32'd1);
    drv_start = 1; drv_cnt = 16'd0; tick();
    tick();
    chk("stray_err_cleared", 32'(bus.oerr), 32'd0);
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
